// File: rtl/conv1_frame_sequencer_if.sv
// Bus bundle between the conv1 frame sequencer and its neighbours.
//   s_axis_*       : pixel stream from the DMA/AXI source (ready driven by sequencer)
//   o_wr_*         : conv1 line-buffer write port
//   o_win_*        : window request towards the line buffer / MAC array
//   i_win_ready    : downstream window accept
// master = sequencer side, slave = source/buffer/MAC side.
interface conv1_frame_sequencer_if;
    logic [7:0] s_axis_data;
    logic       s_axis_valid;
    logic       o_s_axis_ready;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_win_valid;
    logic       i_win_ready;
    logic [4:0] o_win_col;
    logic [4:0] o_win_row;
    logic [2:0] o_win_top_slot;

    modport master (
        input  s_axis_data, s_axis_valid, i_win_ready,
        output o_s_axis_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_win_valid, o_win_col, o_win_row, o_win_top_slot
    );

    modport slave (
        output s_axis_data, s_axis_valid, i_win_ready,
        input  o_s_axis_ready, o_wr_en, o_wr_addr, o_wr_data,
               o_win_valid, o_win_col, o_win_row, o_win_top_slot
    );
endinterface

// File: rtl/conv1_frame_sequencer.sv
// Sequences one HEIGHT x WIDTH frame into the K-slot conv1 line buffer:
// primes K lines, then alternates one output row of window requests with
// loading the next input line into the slot just freed.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_start  : frame start, honoured only when idle
//   i_abort  : drop the current frame, wins over a same-cycle beat/accept
//   bus      : pixel stream, line-buffer write port, window request
//   o_busy   : any state other than idle
//   o_done   : one-cycle frame-complete pulse
module conv1_frame_sequencer #(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned HEIGHT = 28,
    parameter int unsigned K      = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    conv1_frame_sequencer_if.master       bus,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int unsigned COL_W  = 5;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned ADDR_W = 8;

    localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0]  LAST_WIN_COL = COL_W'(WIDTH - K);
    localparam logic [COL_W-1:0]  LAST_OUT_ROW = COL_W'(HEIGHT - K);
    localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(K - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_SCAN, ST_LOAD, ST_DONE
    } state_t;

    state_t              r_state,    w_nxt_state;
    logic [SLOT_W-1:0]   r_wr_row,   w_nxt_wr_row;
    logic [COL_W-1:0]    r_col,      w_nxt_col;
    logic [COL_W-1:0]    r_out_row,  w_nxt_out_row;
    logic [SLOT_W-1:0]   r_top_slot, w_nxt_top_slot;

    logic                w_ready;
    logic                w_beat;
    logic                w_scan;
    logic [SLOT_W-1:0]   w_slot;
    logic [ADDR_W-1:0]   w_addr;

    // Ready drops during an abort so the source never sees a beat we discard.
    assign w_ready = ((r_state == ST_FILL) || (r_state == ST_LOAD)) && !i_abort;
    assign w_beat  = w_ready && bus.s_axis_valid;
    assign w_scan  = (r_state == ST_SCAN);

    // Priming writes slot=wr_row; refills overwrite the slot of the retired top line.
    assign w_slot = (r_state == ST_LOAD) ? r_top_slot : r_wr_row;
    assign w_addr = ADDR_W'(w_slot) * ADDR_W'(WIDTH) + ADDR_W'(r_col);

    assign bus.o_s_axis_ready = w_ready;
    assign bus.o_wr_en        = w_beat;
    assign bus.o_wr_addr      = w_beat ? w_addr : '0;
    assign bus.o_wr_data      = w_beat ? bus.s_axis_data : '0;
    assign bus.o_win_valid    = w_scan;
    assign bus.o_win_col      = w_scan ? r_col      : '0;
    assign bus.o_win_row      = w_scan ? r_out_row  : '0;
    assign bus.o_win_top_slot = w_scan ? r_top_slot : '0;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_done             = (r_state == ST_DONE);

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_wr_row   <= '0;
            r_col      <= '0;
            r_out_row  <= '0;
            r_top_slot <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_wr_row   <= w_nxt_wr_row;
            r_col      <= w_nxt_col;
            r_out_row  <= w_nxt_out_row;
            r_top_slot <= w_nxt_top_slot;
        end
    end

    // Next-state and counter update.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_wr_row   = r_wr_row;
        w_nxt_col      = r_col;
        w_nxt_out_row  = r_out_row;
        w_nxt_top_slot = r_top_slot;

        if (i_abort && (r_state != ST_IDLE)) begin
            w_nxt_state    = ST_IDLE;
            w_nxt_wr_row   = '0;
            w_nxt_col      = '0;
            w_nxt_out_row  = '0;
            w_nxt_top_slot = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_nxt_state    = ST_FILL;
                        w_nxt_wr_row   = '0;
                        w_nxt_col      = '0;
                        w_nxt_out_row  = '0;
                        w_nxt_top_slot = '0;
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        if (r_col == LAST_COL) begin
                            w_nxt_col = '0;
                            if (r_wr_row == LAST_SLOT) begin
                                w_nxt_state    = ST_SCAN;
                                w_nxt_top_slot = '0;
                                w_nxt_out_row  = '0;
                            end else begin
                                w_nxt_wr_row = r_wr_row + SLOT_W'(1);
                            end
                        end else begin
                            w_nxt_col = r_col + COL_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (bus.i_win_ready) begin
                        if (r_col == LAST_WIN_COL) begin
                            w_nxt_col   = '0;
                            w_nxt_state = (r_out_row == LAST_OUT_ROW) ? ST_DONE : ST_LOAD;
                        end else begin
                            w_nxt_col = r_col + COL_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_beat) begin
                        if (r_col == LAST_COL) begin
                            w_nxt_col      = '0;
                            w_nxt_top_slot = (r_top_slot == LAST_SLOT) ? '0 : r_top_slot + SLOT_W'(1);
                            w_nxt_out_row  = r_out_row + COL_W'(1);
                            w_nxt_state    = ST_SCAN;
                        end else begin
                            w_nxt_col = r_col + COL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    w_nxt_state = ST_IDLE;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv1_frame_sequencer.md
Name: conv1_frame_sequencer

Overview:
- Controller that sequences one HEIGHT x WIDTH 8-bit frame from the AXI-stream pixel source into the 5-line conv1 window buffer and schedules 5x5 window reads.
- Primes K lines, then alternates two phases: scan one output row of windows, then load one new input line into the freed slot.
- Owns s_axis backpressure, line-buffer write addressing, window position/slot selection and the frame-done pulse. Sits between the DMA/AXI source and the conv1 line buffer and MAC array.

Parameters:
WIDTH, 28, pixels per input line
HEIGHT, 28, input lines per frame
K, 5, kernel size; number of line slots in the buffer

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_start  in  1  start-frame pulse; accepted only in IDLE
i_abort  in  1  abandon the current frame
s_axis_data  in  8  pixel
s_axis_valid  in  1  pixel valid
o_s_axis_ready  out  1  pixel accept
o_wr_en  out  1  line-buffer write strobe
o_wr_addr  out  8  write address, slot*WIDTH+col
o_wr_data  out  8  write data
o_win_valid  out  1  window request
i_win_ready  in  1  downstream accepts the window
o_win_col  out  5  window left column, 0..WIDTH-K
o_win_row  out  5  output row, 0..HEIGHT-K
o_win_top_slot  out  3  slot holding the window's top line
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (i_rst=0 at a clock edge): state IDLE; all counters 0; every output 0. Reset mid-frame discards the frame, with no o_done.
- States: IDLE, FILL, SCAN, LOAD, DONE. State and counters are registered.
- Beat = s_axis_valid & o_s_axis_ready. o_s_axis_ready=1 only in FILL and LOAD.
- o_wr_en = beat; o_wr_data = s_axis_data; o_wr_addr = slot*WIDTH+col. All three are combinational, so the write lands on the same edge as the beat.
- IDLE: i_start=1 -> FILL next cycle; wr_row, col, out_row and top_slot cleared.
- FILL: each beat writes slot=wr_row, col=col; col increments and wraps at WIDTH-1, with wr_row++ on wrap.
  - Beat at wr_row=K-1, col=WIDTH-1 -> SCAN, with top_slot=0 and out_row=0.
- SCAN: o_win_valid=1; o_win_col=scan col; o_win_row=out_row; o_win_top_slot=top_slot.
  - Advance only on o_win_valid & i_win_ready. Hold the outputs stable while stalled.
  - Accept at col=WIDTH-K: if out_row=HEIGHT-K -> DONE, else -> LOAD with col=0.
- LOAD: beats write slot=top_slot, cols 0..WIDTH-1.
  - On the beat at col=WIDTH-1: top_slot <= (top_slot+1) mod K; out_row++; -> SCAN with col=0.
- DONE: o_done=1 for one cycle -> IDLE.
- Window line order is top_slot, top_slot+1, ..., top_slot+K-1, all mod K. The buffer resolves this from o_win_top_slot.
- Gaps in s_axis_valid stall FILL/LOAD with no state change. Data offered outside FILL/LOAD is not accepted.
- i_start outside IDLE is ignored.
- i_abort in any non-IDLE state -> IDLE next cycle, with no o_done and no write. In that cycle the abort has priority over a coincident beat or window accept. i_abort in IDLE has no effect.
- Per frame: WIDTH*HEIGHT=784 writes and (WIDTH-K+1)*(HEIGHT-K+1)=576 window accepts.
- No-stall cycle count, with the start pulse at cycle 0:
  - FILL occupies cycles 1..140.
  - First o_win_valid at cycle 141.
  - Total active cycles = 140 + 24*24 + 23*28 = 1360.
  - o_done at cycle 1361; IDLE at cycle 1362.

Test Plan:
- Full frame, valid and i_win_ready held high, raster pixels 0..783 mod 256 -> exactly 784 writes with correct addresses (pixel 140 lands at addr 0). 576 windows, with col 0..23 per row. top_slot sequence 0,1,2,3,4,0,...; o_done only at cycle 1361.
- Random s_axis_valid gaps (50%) plus random i_win_ready stalls -> same write/window sequence. Window outputs stable during stalls. No beats accepted during SCAN.
- i_start pulsed during SCAN of row 3 -> ignored; the frame completes normally with a single o_done.
- i_abort on the 10th beat of LOAD for row 7 -> that beat not written; IDLE next cycle; o_busy=0; no o_done. A following i_start runs a clean full frame.
- i_rst=0 for one cycle mid-SCAN -> all outputs 0 next cycle; state IDLE; ready stays 0 until i_start.
- Back-to-back frames, i_start asserted in the cycle after o_done -> second frame starts with wr_row=0, top_slot=0, and produces an identical window stream.
